// File: rtl/dcim_add_pkg.sv
// Shared constants and helpers for the DCIM pipelined adders.
// Saturation patterns are built wide, then sized at the use site.
package dcim_add_pkg;

  localparam int STAGES_MAX = 8;
  localparam int SAT_WMAX   = 256;

  function automatic logic [SAT_WMAX-1:0] SAT_POS(input int w);
    logic [SAT_WMAX-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_WMAX; i++)
      r[i] = (i < w - 1);
    return r;
  endfunction

  function automatic logic [SAT_WMAX-1:0] SAT_NEG(input int w);
    logic [SAT_WMAX-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_WMAX; i++)
      r[i] = (i == w - 1);
    return r;
  endfunction

  function automatic bit cfg_ok(input int w, input int s);
    return (s >= 1) && (s <= STAGES_MAX) &&
           (w >= s) && (w <= SAT_WMAX) && (w % s == 0);
  endfunction

endpackage

// File: rtl/s_cla_seg.sv
// Combinational W-bit carry-lookahead segment.
// Each carry is the flattened generate/propagate sum-of-products.
module s_cla_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         gp;
  logic         pp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gp = 1'b0;
    pp = 1'b1;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      gp = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        gp = gp | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gp | (pp & cin);
    end
  end

  assign sum      = p ^ c[W-1:0];
  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/s_cla_pipe.sv
// Pipelined signed CLA adder: one segment per stage, skewed operands,
// deskewed sums, global-enable valid/ready flow control.
module s_cla_pipe
  import dcim_add_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SEG_W = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] SPOS = WIDTH'(SAT_POS(WIDTH));
  localparam logic [WIDTH-1:0] SNEG = WIDTH'(SAT_NEG(WIDTH));

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("s_cla_pipe: WIDTH must be a multiple of STAGES in 1..%0d",
           STAGES_MAX);
  end

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = WIDTH - k * SEG_W;
    localparam int LOW = (k + 1) * SEG_W;

    logic [REM-1:0]   au;
    logic [REM-1:0]   bu;
    logic [LOW-1:0]   acc;
    logic [SEG_W-1:0] sum;
    logic             cin;
    logic             vin;
    logic             satin;
    logic             cout;
    logic             cmsb;
    logic             v_q;

    if (k == 0) begin : g_src
      assign au    = a;
      assign bu    = b;
      assign cin   = ci;
      assign vin   = in_valid;
      assign satin = sat;
      assign acc   = sum;
    end else begin : g_src
      assign au    = g_stg[k-1].g_mid.a_q;
      assign bu    = g_stg[k-1].g_mid.b_q;
      assign cin   = g_stg[k-1].g_mid.c_q;
      assign vin   = g_stg[k-1].v_q;
      assign satin = g_stg[k-1].g_mid.sat_q;
      assign acc   = {sum, g_stg[k-1].g_mid.sum_q};
    end

    s_cla_seg #(
      .W (SEG_W)
    ) u_seg (
      .a        (au[SEG_W-1:0]),
      .b        (bu[SEG_W-1:0]),
      .cin      (cin),
      .sum      (sum),
      .cout     (cout),
      .c_msb_in (cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   v_q <= 1'b0;
      else if (adv) v_q <= vin;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [REM-SEG_W-1:0] a_q;
      logic [REM-SEG_W-1:0] b_q;
      logic [LOW-1:0]       sum_q;
      logic                 c_q;
      logic                 sat_q;
      logic                 cmsb_unused;

      assign cmsb_unused = cmsb;

      // Bubbles leave the data registers untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
          sat_q <= 1'b0;
        end else if (adv && vin) begin
          a_q   <= au[REM-1:SEG_W];
          b_q   <= bu[REM-1:SEG_W];
          sum_q <= acc;
          c_q   <= cout;
          sat_q <= satin;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] s_d;
      logic [WIDTH-1:0] s_q;
      logic             ovf_d;
      logic             co_q;
      logic             ovf_q;

      // On overflow both operand MSBs agree, so a's MSB picks the rail.
      assign ovf_d = cout ^ cmsb;
      assign s_d   = (satin && ovf_d) ?
                     (au[REM-1] ? SNEG : SPOS) : acc;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q   <= '0;
          co_q  <= 1'b0;
          ovf_q <= 1'b0;
        end else if (adv && vin) begin
          s_q   <= s_d;
          co_q  <= cout;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign s         = g_stg[STAGES-1].g_last.s_q;
  assign co        = g_stg[STAGES-1].g_last.co_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_s_cla_pipe.sv
// Scoreboard bench for s_cla_pipe at WIDTH=24, STAGES=3.
module tb_s_cla_pipe;

  localparam int W  = 24;
  localparam int ST = 3;
  localparam int NV = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  logic [W-1:0] va [NV] = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h7FFFFF,
                            24'h800000, 24'h800000, 24'h123456, 24'hFFFFFF,
                            24'h7FFFFF, 24'h000FFF};
  logic [W-1:0] vb [NV] = '{24'h0000FF, 24'h000000, 24'h000001, 24'h000001,
                            24'hFFFFFF, 24'hFFFFFF, 24'h654321, 24'hFFFFFF,
                            24'h7FFFFF, 24'h00F001};
  logic         vc [NV] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 0};
  logic         vs [NV] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
  logic [W+1:0] ve [NV] = '{{24'h000100, 1'b0, 1'b0},
                            {24'h000000, 1'b1, 1'b0},
                            {24'h800000, 1'b0, 1'b1},
                            {24'h7FFFFF, 1'b0, 1'b1},
                            {24'h800000, 1'b1, 1'b1},
                            {24'h7FFFFF, 1'b1, 1'b1},
                            {24'h777778, 1'b0, 1'b0},
                            {24'hFFFFFE, 1'b1, 1'b0},
                            {24'h7FFFFF, 1'b0, 1'b1},
                            {24'h010000, 1'b0, 1'b0}};

  always #5 clk = ~clk;

  s_cla_pipe #(
    .WIDTH  (W),
    .STAGES (ST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c, input logic m);
    int xi, yi, t;
    logic [W:0] u;
    logic [W-1:0] r;
    logic v;
    xi = {{8{x[W-1]}}, x};
    yi = {{8{y[W-1]}}, y};
    t  = xi + yi + (c ? 1 : 0);
    u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v  = (t > 8388607) || (t < -8388608);
    r  = u[W-1:0];
    if (m && v) r = (t < 0) ? 24'h800000 : 24'h7FFFFF;
    return {r, u[W], v};
  endfunction

  task test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if ({s, co, ovf} !== '0) begin
      errors++;
      $display("FAIL rst_data got s=%h co=%b ovf=%b want 0", s, co, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_single();
    int lat;
    logic [W+1:0] e;
    @(negedge clk);
    a = 24'h000001; b = 24'h0000FF; ci = 0; sat = 0;
    in_valid = 1; out_ready = 1;
    exp_q.push_back({24'h000100, 1'b0, 1'b0});
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != ST) begin
      errors++;
      $display("FAIL single_latency got %0d want %0d", lat, ST);
    end
    e = exp_q.pop_front();
    checks++;
    if ({s, co, ovf} !== e) begin
      errors++;
      $display("FAIL single_result got %h/%b/%b want %h/%b/%b",
               s, co, ovf, e[W+1:2], e[1], e[0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_dup got out_valid=%b want 0", out_valid);
    end
  endtask

  task test_back_to_back();
    int n_in, n_out;
    logic [W+1:0] e;
    n_in = 0; n_out = 0; out_ready = 1;
    for (int cyc = 0; cyc < 60 && n_out < NV; cyc++) begin
      @(negedge clk);
      if (n_in < NV) begin
        in_valid = 1;
        a = va[n_in]; b = vb[n_in]; ci = vc[n_in]; sat = vs[n_in];
      end else begin
        in_valid = 0;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got s=%h want no output", s);
        end else begin
          e = exp_q.pop_front();
          if ({s, co, ovf} !== e) begin
            errors++;
            $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/%b/%b",
                     n_out, s, co, ovf, e[W+1:2], e[1], e[0]);
          end
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ve[n_in]);
        n_in++;
      end
    end
    in_valid = 0;
    checks++;
    if (n_out != NV || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d results want %0d", n_out, NV);
    end
  endtask

  task test_backpressure();
    int n_in, n_out;
    logic took, stall_prev;
    logic [W+1:0] e, ps;
    n_in = 0; n_out = 0; took = 1; stall_prev = 0; ps = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60 && n_out < NV; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc == 5 || cyc == 6);
      if (took || !in_valid) begin
        if (n_in < NV) begin
          in_valid = 1;
          a = W'($urandom); b = W'($urandom);
          ci = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 0;
        end
      end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready cyc %0d got %b want %b",
                 cyc, in_ready, !(out_valid && !out_ready));
      end
      if (stall_prev) begin
        checks++;
        if ({s, co, ovf} !== ps) begin
          errors++;
          $display("FAIL bp_stable cyc %0d got %h want %h",
                   cyc, {s, co, ovf}, ps);
        end
      end
      stall_prev = out_valid && !out_ready;
      ps = {s, co, ovf};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got s=%h want no output", s);
        end else begin
          e = exp_q.pop_front();
          if ({s, co, ovf} !== e) begin
            errors++;
            $display("FAIL bp_result[%0d] got %h/%b/%b want %h/%b/%b",
                     n_out, s, co, ovf, e[W+1:2], e[1], e[0]);
          end
        end
        n_out++;
      end
      took = in_valid && in_ready;
      if (took) begin
        exp_q.push_back(model(a, b, ci, sat));
        n_in++;
      end
    end
    in_valid = 0;
    out_ready = 1;
    checks++;
    if (n_out != NV || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d results want %0d", n_out, NV);
    end
  endtask

  task test_reset_mid();
    int lat, stale;
    logic [W+1:0] e;
    exp_q.delete();
    @(negedge clk);
    out_ready = 1; in_valid = 1; ci = 0; sat = 0;
    a = 24'h800000; b = 24'hFFFFFF;
    @(negedge clk);
    a = 24'h000010; b = 24'h000020;
    @(negedge clk);
    a = 24'h000100; b = 24'h000200;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #1;
    checks++;
    if ({out_valid, s, co, ovf} !== {1'b1, 24'h7FFFFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rm_pre got v=%b s=%h co=%b ovf=%b want 1/7fffff/1/1",
               out_valid, s, co, ovf);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, s, co, ovf} !== '0) begin
      errors++;
      $display("FAIL rm_async got v=%b s=%h co=%b ovf=%b want 0",
               out_valid, s, co, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rm_stale got %0d outputs want 0", stale);
    end
    a = 24'h0ABCDE; b = 24'h012345; ci = 1; sat = 0; in_valid = 1;
    exp_q.push_back(model(a, b, ci, sat));
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != ST) begin
      errors++;
      $display("FAIL rm_latency got %0d want %0d", lat, ST);
    end
    e = exp_q.pop_front();
    checks++;
    if ({s, co, ovf} !== e) begin
      errors++;
      $display("FAIL rm_result got %h/%b/%b want %h/%b/%b",
               s, co, ovf, e[W+1:2], e[1], e[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
